// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC and fetch controller feeding decode through a one-entry fetch register
// Optional macro WRAP_TRAP_EN: trap on fetch from the all-ones PC instead of wrapping silently.
module fetch_sequencer #(
  parameter int              AW          = 8,
  parameter int              IW          = 16,
  parameter logic [AW-1:0]   RESET_PC    = '0,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] im_addr,
  input  logic [IW-1:0] im_data,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          br_take,
  input  logic [AW-1:0] br_target,
  output logic          halted,
  output logic          fault
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          slot_free;
  logic          is_halt;
  logic          wrap_trap;

  assign im_addr   = pc;
  assign slot_free = !if_valid || if_ready;
  assign is_halt   = (im_data[IW-1:IW-4] == HALT_OPCODE);

`ifdef WRAP_TRAP_EN
  logic fault_q;
  assign wrap_trap = (pc == {AW{1'b1}});
  assign fault     = fault_q;
`else
  assign wrap_trap = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      halted   <= 1'b0;
`ifdef WRAP_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      // A completed handshake empties the slot unless a capture below refills it.
      if (if_valid && if_ready) if_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (br_take) pc <= br_target;
          if (start) state <= RUN;
        end
        RUN: begin
          if (br_take) begin
            pc       <= br_target;
            if_valid <= 1'b0;
          end else if (slot_free) begin
            if_instr <= im_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (wrap_trap) begin
              state   <= HALT;
              halted  <= 1'b1;
`ifdef WRAP_TRAP_EN
              fault_q <= 1'b1;
`endif
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        HALT: begin
          // Resume past the halting instruction; capture still waits for a free slot.
          if (start && !fault) begin
            pc     <= pc + 1'b1;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that sequences the combinational instruction memory (8-bit address in, 16-bit instruction out).
- Holds the PC and drives the memory address.
- Captures the returned instruction into a one-entry fetch register.
- Presents it to decode over a valid/ready handshake, and handles branch redirect, halt opcode and stall.

Parameters:
- AW, 8, PC / instruction-memory address width.
- IW, 16, instruction width.
- RESET_PC, 8'd0, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instruction bits [IW-1:IW-4] that halts fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  leave IDLE or HALT and begin or resume fetching.
- im_addr  output  AW  address to instruction memory; equals pc register, combinational.
- im_data  input  IW  instruction from memory; combinational in the same cycle as im_addr.
- if_valid  output  1  fetch register holds an instruction for decode.
- if_ready  input  1  decode accepts the instruction this cycle.
- if_instr  output  IW  fetched instruction.
- if_pc  output  AW  address the instruction was fetched from.
- br_take  input  1  redirect request from execute.
- br_target  input  AW  redirect address.
- halted  output  1  high while in HALT.
- fault  output  1  PC-wrap trap flag, sticky; tied 0 when the optional feature is absent.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0.
- Transfer: a transfer occurs on any edge where if_valid && if_ready. Slot free = !if_valid || if_ready.
- IDLE:
  - No capture.
  - br_take loads pc<=br_target and stays in IDLE.
  - start -> RUN.
- RUN, evaluated in priority order each edge:
  1. br_take: pc<=br_target, if_valid<=0 (buffered instruction flushed, whether or not it transferred), no capture.
  2. Slot free: if_instr<=im_data, if_pc<=pc, if_valid<=1.
     - If im_data[IW-1:IW-4]==HALT_OPCODE: pc unchanged, state->HALT.
     - Otherwise pc<=pc+1 (mod 2^AW).
  3. Otherwise (stall, valid && !ready): pc, if_instr, if_pc and if_valid hold.
- Latency and throughput:
  - start sampled at edge N gives RUN; edge N+1 captures mem[RESET_PC], so if_valid is high after N+1.
  - With if_ready held high, one instruction per cycle.
  - After br_take at edge M, mem[br_target] is valid after M+1 (one bubble).
- HALT:
  - halted=1, no capture, br_take ignored.
  - Pending instruction stays valid until transferred, then if_valid<=0.
  - start: pc<=pc+1, state->RUN, halted<=0; takes effect even if the halt instruction is still pending, since capture waits for a free slot.
- Simultaneous events:
  - start and br_take in IDLE: pc<=br_target and state->RUN.
  - Transfer and br_take together: the transfer counts and the slot empties.
- Wrap: pc 8'hFF increments to 8'h00 (see optional feature).
- Reset mid-operation discards the pending instruction with no handshake.

Optional Feature:
- Macro: WRAP_TRAP_EN.
- Defined:
  - A capture in RUN at pc==all-ones (no br_take, not a halt opcode) presents the instruction, holds pc, sets fault<=1 and enters HALT.
  - fault is sticky until rst; start from HALT is ignored while fault=1.
- Undefined: pc wraps silently to 0 and fault is constant 0.

Test Plan:
- Reset then start=1 for one cycle, if_ready=1, memory mem[i]=16'h1000+i -> if_valid rises one cycle after RUN entry; if_pc/if_instr = 0/1000, 1/1001, 2/1002 on consecutive cycles.
- br_take with br_target=84 mid-stream -> next cycle if_valid=0; following cycle if_pc=84, if_instr=mem[84]; then 85. Repeat with targets 42, 34 and 15.
- Hold if_ready=0 for 3 cycles at pc=5 -> if_instr/if_pc stable at pc 5 and im_addr=6 stable; release -> pc 6 presented next cycle, no instruction lost or duplicated.
- mem[42]=16'hF000, branch to 42 -> instruction F000 presented, halted=1, im_addr stays 42; accept -> if_valid=0; start -> if_pc=43 next.
- br_take to 8'hFF, mem[FF]=16'h1234, not halt:
  - Without macro: if_pc FF then 00.
  - With WRAP_TRAP_EN: fault=1, halted=1, start ignored.
- Assert rst while if_valid=1 and stalled -> outputs zero immediately, pc=RESET_PC, state IDLE with no edge required.
